// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port of a synchronous FIFO as seen by the UART transmitter.
// The transmitter is the master (it issues pops); the FIFO is the slave.
interface fifo_uart_tx_if;
    logic [7:0] fiData;   // read data, valid the cycle after fiRe
    logic       fiEmpty;
    logic       fiRe;     // one-cycle pop strobe

    modport master (output fiRe, input fiData, input fiEmpty);
    modport slave (input fiRe, output fiData, output fiEmpty);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends each as an 8N1 UART frame.
// Optionally halts for good once a designated terminator byte has been sent.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter logic [7:0]  END_TOKEN     = 8'h2D,
    parameter bit          STOP_ON_TOKEN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           isFinish,
    output logic [15:0]    byteCount
);
    localparam int unsigned CntWidth = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StStop,
        StDone
    } stateT;

    stateT               stateQ, stateD;
    logic                txQ, txD;
    logic [7:0]          shiftQ, shiftD;
    logic [2:0]          bitIdxQ, bitIdxD;
    logic [CntWidth-1:0] baudCntQ, baudCntD;
    logic [15:0]         byteCountQ, byteCountD;
    logic                popReq;
    logic                fiRe;
    logic                baudEnd;
    logic [2:0]          nextIdx;

    assign baudEnd = (baudCntQ == CntLast);
    assign nextIdx = bitIdxQ + 3'd1;

    // Next-state logic; tx is computed one cycle ahead so the line comes straight from a flop.
    always_comb begin
        stateD     = stateQ;
        txD        = txQ;
        shiftD     = shiftQ;
        bitIdxD    = bitIdxQ;
        baudCntD   = baudCntQ;
        byteCountD = byteCountQ;
        popReq     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                txD = 1'b1;
                if (enable && !fifo.fiEmpty && !isFinish) begin
                    popReq = 1'b1;
                    stateD = StPop;
                end
            end
            // FIFO read latency: data appears one cycle after the pop.
            StPop: stateD = StLoad;
            StLoad: begin
                shiftD   = fifo.fiData;
                bitIdxD  = 3'd0;
                baudCntD = '0;
                txD      = 1'b0;  // start bit begins on entry to StStart
                stateD   = StStart;
            end
            StStart: begin
                if (baudEnd) begin
                    baudCntD = '0;
                    txD      = shiftQ[0];
                    stateD   = StData;
                end else begin
                    baudCntD = baudCntQ + CntWidth'(1);
                end
            end
            StData: begin
                if (baudEnd) begin
                    baudCntD = '0;
                    if (bitIdxQ == 3'd7) begin
                        txD    = 1'b1;
                        stateD = StStop;
                    end else begin
                        bitIdxD = nextIdx;
                        txD     = shiftQ[nextIdx];
                    end
                end else begin
                    baudCntD = baudCntQ + CntWidth'(1);
                end
            end
            StStop: begin
                txD = 1'b1;
                if (baudEnd) begin
                    baudCntD   = '0;
                    byteCountD = byteCountQ + 16'd1;
                    if ((shiftQ == END_TOKEN) && STOP_ON_TOKEN) begin
                        stateD = StDone;
                    end else begin
                        stateD = StIdle;
                    end
                end else begin
                    baudCntD = baudCntQ + CntWidth'(1);
                end
            end
            StDone: txD = 1'b1;
            default: begin
                txD    = 1'b1;
                stateD = StIdle;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StIdle;
            txQ        <= 1'b1;
            shiftQ     <= '0;
            bitIdxQ    <= '0;
            baudCntQ   <= '0;
            byteCountQ <= '0;
        end else begin
            stateQ     <= stateD;
            txQ        <= txD;
            shiftQ     <= shiftD;
            bitIdxQ    <= bitIdxD;
            baudCntQ   <= baudCntD;
            byteCountQ <= byteCountD;
        end
    end

    // The pop is gated by reset so a reset cycle can never consume a FIFO entry.
    assign fiRe      = popReq && !reset;
    assign fifo.fiRe = fiRe;
    assign tx        = txQ;
    assign busy      = fiRe || (stateQ inside {StPop, StLoad, StStart, StData, StStop});
    assign isFinish  = (stateQ == StDone);
    assign byteCount = byteCountQ;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: table vectors, hand sequences and randomized traffic against a
// cycle-offset reference model of UART framing for fifo_uart_tx.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam logic [7:0] TOKEN = 8'h2D;
    localparam int FrameCycles = 3 + 10 * CPB;  // fiRe cycle through last stop-bit cycle

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  frame;     // frame[i] = line level during bit i (start..stop)
        int          busyLen;
        logic [15:0] cntAfter;
    } vecT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        txA, busyA, finA;
    logic [15:0] cntA;
    logic        rstB = 1'b1;
    logic        txB, busyB, finB;
    logic [15:0] cntB;

    fifo_uart_tx_if ifA ();
    fifo_uart_tx_if ifB ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .END_TOKEN(TOKEN), .STOP_ON_TOKEN(1'b1)) dutA (
        .clk(clk), .reset(reset), .enable(enable), .fifo(ifA),
        .tx(txA), .busy(busyA), .isFinish(finA), .byteCount(cntA)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .END_TOKEN(TOKEN), .STOP_ON_TOKEN(1'b0)) dutB (
        .clk(clk), .reset(rstB), .enable(1'b1), .fifo(ifB),
        .tx(txB), .busy(busyB), .isFinish(finB), .byteCount(cntB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO models: pop on the edge that samples fiRe, data valid the next cycle.
    logic [7:0] qA[$];
    logic [7:0] mq[$];  // reference model's own copy of FIFO A contents
    logic [7:0] qB[$];

    initial begin
        ifA.fiData <= 8'h00;
        ifA.fiEmpty = 1'b1;
        forever begin
            @(posedge clk);
            if (ifA.fiRe === 1'b1 && qA.size() != 0) ifA.fiData <= qA.pop_front();
            #2 ifA.fiEmpty = (qA.size() == 0);
        end
    end

    initial begin
        ifB.fiData <= 8'h00;
        ifB.fiEmpty = 1'b1;
        forever begin
            @(posedge clk);
            if (ifB.fiRe === 1'b1 && qB.size() != 0) ifB.fiData <= qB.pop_front();
            #2 ifB.fiEmpty = (qB.size() == 0);
        end
    end

    task automatic pushA(input logic [7:0] b);
        qA.push_back(b);
        mq.push_back(b);
    endtask

    // Reference model: a frame is described only by the cycle of its pop.
    bit         checkOn = 1'b0;
    int         phaseStart = -1000;
    logic [7:0] curByte = 8'h00;
    bit         modFin = 1'b0;
    logic [15:0] modCnt = 16'd0;

    task automatic modelStep();
        int off;
        int b;
        bit inFrame;
        bit expRe;
        bit expTx;
        off = cyc - phaseStart;
        inFrame = (off >= 1) && (off <= FrameCycles - 1);
        expRe = !reset && !inFrame && !modFin && enable && (mq.size() != 0);
        expTx = 1'b1;
        if (inFrame && off >= 3) begin
            b = (off - 3) / CPB;
            if (b == 0) expTx = 1'b0;
            else if (b <= 8) expTx = curByte[b - 1];
        end
        check("model fiRe", 32'(ifA.fiRe), 32'(expRe));
        check("model busy", 32'(busyA), 32'(expRe || inFrame));
        check("model tx", 32'(txA), 32'(expTx));
        check("model byteCount", 32'(cntA), 32'(modCnt));
        check("model isFinish", 32'(finA), 32'(modFin));
        if (reset) begin
            phaseStart = -1000;
            modFin = 1'b0;
            modCnt = 16'd0;
        end else begin
            if (inFrame && off == FrameCycles - 1) begin
                modCnt = modCnt + 16'd1;
                if (curByte == TOKEN) modFin = 1'b1;
            end
            if (expRe) begin
                phaseStart = cyc;
                curByte = mq.pop_front();
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checkOn) modelStep();
    end

    // DUT B: simple UART receiver plus pop counter.
    logic [7:0] rxB[$];
    logic [7:0] rxByte;
    int         reB = 0;

    initial forever begin
        @(negedge clk);
        if (rstB === 1'b0 && ifB.fiRe === 1'b1) reB++;
    end

    initial forever begin
        @(negedge clk);
        if (rstB === 1'b0 && txB === 1'b0) begin
            repeat (CPB + 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                rxByte[i] = txB;
                repeat (CPB) @(negedge clk);
            end
            check("B stop bit", 32'(txB), 32'd1);
            rxB.push_back(rxByte);
            repeat (2) @(negedge clk);
        end
    end

    initial begin
        qB.push_back(8'h2D);
        qB.push_back(8'h30);
        repeat (2) @(posedge clk);
        #1 rstB = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitRe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifA.fiRe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    vecT vecs[5];
    bit  ok;
    int  busyCnt;
    int  reCycles[$];
    logic [7:0] rb;

    initial begin
        vecs[0] = '{8'hA5, 10'b11_0100_1010, FrameCycles, 16'd1};
        vecs[1] = '{8'h55, 10'b10_1010_1010, FrameCycles, 16'd2};
        vecs[2] = '{8'h00, 10'b10_0000_0000, FrameCycles, 16'd3};
        vecs[3] = '{8'hFF, 10'b11_1111_1110, FrameCycles, 16'd4};
        vecs[4] = '{8'h41, 10'b10_1000_0010, FrameCycles, 16'd5};

        // Reset state
        tick(2);
        checkOn = 1'b1;
        @(negedge clk);
        check("reset tx", 32'(txA), 32'd1);
        check("reset busy", 32'(busyA), 32'd0);
        check("reset fiRe", 32'(ifA.fiRe), 32'd0);
        check("reset isFinish", 32'(finA), 32'd0);
        check("reset byteCount", 32'(cntA), 32'd0);
        tick(1);
        reset = 1'b0;

        // Enabled with an empty FIFO: nothing may happen
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("empty fiRe", 32'(ifA.fiRe), 32'd0);
            check("empty tx", 32'(txA), 32'd1);
            check("empty busy", 32'(busyA), 32'd0);
        end
        tick(1);

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            pushA(vecs[v].data);
            waitRe(ok);
            check("table fiRe seen", 32'(ok), 32'd1);
            busyCnt = busyA ? 1 : 0;
            for (int off = 1; off <= 50; off++) begin
                @(negedge clk);
                if (busyA) busyCnt++;
                if (off >= 3 && off < 3 + 10 * CPB)
                    check("table tx", 32'(txA), 32'(vecs[v].frame[(off - 3) / CPB]));
            end
            check("table busy length", 32'(busyCnt), 32'(vecs[v].busyLen));
            check("table byteCount", 32'(cntA), 32'(vecs[v].cntAfter));
            tick(1);
        end

        // enable dropped mid-frame: frame completes, next pop waits for enable
        pushA(8'h55);
        waitRe(ok);
        check("enable fiRe seen", 32'(ok), 32'd1);
        tick(19);
        enable = 1'b0;
        pushA(8'h41);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("enable low no pop", 32'(ifA.fiRe), 32'd0);
        end
        check("enable frame counted", 32'(cntA), 32'd6);
        tick(1);
        enable = 1'b1;
        waitRe(ok);
        check("enable resume pop", 32'(ok), 32'd1);
        repeat (50) @(negedge clk);
        check("enable resume count", 32'(cntA), 32'd7);
        tick(1);

        // Reset during data bit 3 discards the byte
        pushA(8'hA5);
        waitRe(ok);
        check("midreset fiRe seen", 32'(ok), 32'd1);
        tick(19);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset tx", 32'(txA), 32'd1);
        check("midreset busy", 32'(busyA), 32'd0);
        check("midreset byteCount", 32'(cntA), 32'd0);
        tick(1);
        pushA(8'hC3);
        waitRe(ok);
        check("postreset fiRe seen", 32'(ok), 32'd1);
        repeat (50) @(negedge clk);
        check("postreset byteCount", 32'(cntA), 32'd1);
        tick(1);

        // Randomized traffic, enable toggling and rare resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0 && mq.size() < 4) begin
                rb = 8'($urandom);
                if (rb == TOKEN) rb = 8'h00;
                pushA(rb);
            end
            tick(1);
        end
        reset = 1'b0;
        enable = 1'b0;
        tick(60);
        qA.delete();
        mq.delete();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // Terminator stream: back-to-back frames, then a permanent halt
        enable = 1'b1;
        pushA(8'h41);
        pushA(8'h42);
        pushA(TOKEN);
        pushA(8'h33);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifA.fiRe === 1'b1) reCycles.push_back(cyc);
            if (finA === 1'b1) break;
        end
        check("token isFinish", 32'(finA), 32'd1);
        check("token byteCount", 32'(cntA), 32'd3);
        check("token pop count", 32'(reCycles.size()), 32'd3);
        for (int i = 1; i < reCycles.size(); i++)
            check("b2b pop spacing", 32'(reCycles[i] - reCycles[i - 1]), 32'(FrameCycles));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("done no pop", 32'(ifA.fiRe), 32'd0);
            check("done busy", 32'(busyA), 32'd0);
            check("done tx", 32'(txA), 32'd1);
        end
        check("done fifo untouched", 32'(qA.size()), 32'd1);

        // STOP_ON_TOKEN=0 instance
        check("B isFinish", 32'(finB), 32'd0);
        check("B byteCount", 32'(cntB), 32'd2);
        check("B pop count", 32'(reB), 32'd2);
        check("B frames", 32'(rxB.size()), 32'd2);
        if (rxB.size() == 2) begin
            check("B byte0", 32'(rxB[0]), 32'h2D);
            check("B byte1", 32'(rxB[1]), 32'h30);
        end

        checkOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
